i2s_rx_unit: RTL and testbench

- Receive-side counterpart of the audioport I2S transmitter.
- Deserialises a standard Philips I2S stream (sck/ws/sdi) back into 24-bit left/right sample pairs, and flags each complete frame with a one-cycle tick.
- Used as the loopback/capture block in the audio subsystem and as the golden-side receiver in system benches.
- Runs entirely in one clock domain (clk); the I2S pins are treated as asynchronous inputs and oversampled.

---
 rtl/i2s_rx_unit.sv | 134 +++++++++++++
 tb/tb_i2s_rx_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_unit.sv
// rtl/i2s_rx_unit.sv - Philips I2S receiver: oversampled sck/ws/sdi to left/right sample pairs
module i2s_rx_unit #(
    parameter int AUDIO_BITS = 24,
    parameter int SLOT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic                  sck_in,
    input  logic                  ws_in,
    input  logic                  sdi_in,
    output logic [AUDIO_BITS-1:0] audio0_out,
    output logic [AUDIO_BITS-1:0] audio1_out,
    output logic                  tick_out,
    output logic                  sync_out,
    output logic                  frame_err_out
);
    localparam int CW = $clog2(SLOT_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] DATA_CNT = CW'(AUDIO_BITS);

    typedef enum logic [1:0] {IDLE, SEEK, LEFT, RIGHT} state_t;

    state_t                state, state_next;
    logic [1:0]            sck_sync, ws_sync, sdi_sync;
    logic                  sck_d, prev_ws;
    logic [CW-1:0]         cnt;
    logic [AUDIO_BITS-1:0] shreg, shreg_next, left_hold;
    logic                  rise, ws_chg, slot_end;
    logic                  tick_set, err_set, left_load;

    assign rise     = sck_sync[1] & ~sck_d;
    assign ws_chg   = ws_sync[1] != prev_ws;
    assign slot_end = cnt == LAST_CNT;
    assign sync_out = (state == LEFT) || (state == RIGHT);

    if (AUDIO_BITS > 1) begin : g_shift_wide
        assign shreg_next = {shreg[AUDIO_BITS-2:0], sdi_sync[1]};
    end else begin : g_shift_one
        assign shreg_next = sdi_sync[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
            prev_ws  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck_in};
            ws_sync  <= {ws_sync[0], ws_in};
            sdi_sync <= {sdi_sync[0], sdi_in};
            sck_d    <= sck_sync[1];
            if (rise) prev_ws <= ws_sync[1];
        end
    end

    // The ws-change edge still carries the previous slot's padding bit, so it only restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (!enable_in) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (rise) begin
            if (ws_chg) begin
                cnt <= '0;
            end else begin
                if (cnt < DATA_CNT) shreg <= shreg_next;
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            left_hold     <= '0;
            audio0_out    <= '0;
            audio1_out    <= '0;
            tick_out      <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            state         <= state_next;
            tick_out      <= tick_set;
            frame_err_out <= err_set;
            if (left_load) left_hold <= shreg;
            if (tick_set) begin
                audio0_out <= left_hold;
                audio1_out <= shreg;
            end
        end
    end

    always_comb begin
        state_next = state;
        tick_set   = 1'b0;
        err_set    = 1'b0;
        left_load  = 1'b0;
        if (!enable_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = SEEK;
                SEEK: if (rise && ws_chg && !ws_sync[1]) state_next = LEFT;
                LEFT: begin
                    if (rise) begin
                        if (ws_chg && slot_end && ws_sync[1]) begin
                            left_load  = 1'b1;
                            state_next = RIGHT;
                        end else if (ws_chg || slot_end) begin
                            err_set    = 1'b1;
                            state_next = SEEK;
                        end
                    end
                end
                RIGHT: begin
                    if (rise) begin
                        if (ws_chg && slot_end && !ws_sync[1]) begin
                            tick_set   = 1'b1;
                            state_next = LEFT;
                        end else if (ws_chg || slot_end) begin
                            err_set    = 1'b1;
                            state_next = SEEK;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_rx_unit.sv
// tb/tb_i2s_rx_unit.sv - randomized bench for i2s_rx_unit against a slot-level frame model
module tb_i2s_rx_unit;
    localparam int AB = 24;
    localparam int SB = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_in;
    logic          sck_in, ws_in, sdi_in;
    logic [AB-1:0] audio0_out, audio1_out;
    logic          tick_out, sync_out, frame_err_out;

    i2s_rx_unit #(.AUDIO_BITS(AB), .SLOT_BITS(SB)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_in     (enable_in),
        .sck_in        (sck_in),
        .ws_in         (ws_in),
        .sdi_in        (sdi_in),
        .audio0_out    (audio0_out),
        .audio1_out    (audio1_out),
        .tick_out      (tick_out),
        .sync_out      (sync_out),
        .frame_err_out (frame_err_out)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            tick_cnt = 0;
    int            err_cnt  = 0;
    int            unstable = 0;
    logic [AB-1:0] exp_l[$];
    logic [AB-1:0] exp_r[$];
    logic [AB-1:0] hold_l = '0;
    logic [AB-1:0] hold_r = '0;
    logic [AB-1:0] last0 = '0;
    logic [AB-1:0] last1 = '0;

    logic          s_ws[$];
    int            s_len[$];
    logic [AB-1:0] s_dat[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last0 = audio0_out;
            last1 = audio1_out;
        end else begin
            if (tick_out) begin
                tick_cnt++;
                check_val("tick_sync", 32'(sync_out), 32'd1);
                check_val("tick_err_excl", 32'(frame_err_out), 32'd0);
                if (exp_l.size() > 0) begin
                    check_val("tick_left", 32'(audio0_out), 32'(exp_l.pop_front()));
                    check_val("tick_right", 32'(audio1_out), 32'(exp_r.pop_front()));
                end
            end else if (audio0_out !== last0 || audio1_out !== last1) begin
                unstable++;
            end
            if (frame_err_out) begin
                err_cnt++;
                check_val("err_sync", 32'(sync_out), 32'd0);
            end
            last0 = audio0_out;
            last1 = audio1_out;
        end
    end

    task automatic send_bit(input logic w, input logic d);
        sck_in = 1'b0;
        ws_in  = w;
        sdi_in = d;
        #40;
        sck_in = 1'b1;
        #40;
    endtask

    // Period 0 of a slot carries the previous slot's padding; data is MSB first from period 1.
    task automatic send_slot(input logic w, input int len, input logic [AB-1:0] d);
        for (int k = 0; k < len; k++) begin
            if (k >= 1 && k <= AB) send_bit(w, d[AB-k]);
            else send_bit(w, 1'($urandom));
        end
    endtask

    task automatic clear_slots();
        s_ws.delete();
        s_len.delete();
        s_dat.delete();
    endtask

    task automatic add_slot(input logic w, input int len, input logic [AB-1:0] d);
        s_ws.push_back(w);
        s_len.push_back(len);
        s_dat.push_back(d);
    endtask

    task automatic add_frame(input logic [AB-1:0] l, input logic [AB-1:0] r);
        add_slot(1'b0, SB, l);
        add_slot(1'b1, SB, r);
    endtask

    // Frame-level reference: lock on a ws fall, accept only exact-length slots, emit a pair at each right->left boundary.
    task automatic run_scenario(input string tag, input bit idle_after);
        int            t0, e0, n_tick, n_err;
        bit            locked;
        logic [AB-1:0] stash;
        locked = 1'b0;
        n_tick = 0;
        n_err  = 0;
        stash  = '0;
        for (int i = 0; i < s_len.size(); i++) begin
            if (i > 0) begin
                if (locked) begin
                    if (s_len[i-1] == SB) begin
                        if (!s_ws[i-1]) begin
                            stash = s_dat[i-1];
                        end else begin
                            exp_l.push_back(stash);
                            exp_r.push_back(s_dat[i-1]);
                            hold_l = stash;
                            hold_r = s_dat[i-1];
                            n_tick++;
                        end
                    end else begin
                        n_err++;
                        locked = 1'b0;
                    end
                end else if (!s_ws[i] && s_ws[i-1]) begin
                    locked = 1'b1;
                end
            end
            if (locked && s_len[i] > SB) begin
                n_err++;
                locked = 1'b0;
            end
        end
        t0 = tick_cnt;
        e0 = err_cnt;
        for (int i = 0; i < s_len.size(); i++) send_slot(s_ws[i], s_len[i], s_dat[i]);
        #120;
        check_val({tag, "_ticks"}, 32'(tick_cnt - t0), 32'(n_tick));
        check_val({tag, "_errs"}, 32'(err_cnt - e0), 32'(n_err));
        check_val({tag, "_pending"}, 32'(exp_l.size()), 32'd0);
        check_val({tag, "_hold_l"}, 32'(audio0_out), 32'(hold_l));
        check_val({tag, "_hold_r"}, 32'(audio1_out), 32'(hold_r));
        check_val({tag, "_sync"}, 32'(sync_out), 32'(locked));
        check_val({tag, "_stable"}, 32'(unstable), 32'd0);
        if (idle_after) begin
            enable_in = 1'b0;
            #30;
            check_val({tag, "_idle_sync"}, 32'(sync_out), 32'd0);
            enable_in = 1'b1;
            #20;
        end
    endtask

    initial begin
        int t0;
        rst       = 1'b1;
        enable_in = 1'($urandom);
        sck_in    = 1'($urandom);
        ws_in     = 1'($urandom);
        sdi_in    = 1'($urandom);
        #32;
        check_val("rst_a0", 32'(audio0_out), 32'd0);
        check_val("rst_a1", 32'(audio1_out), 32'd0);
        check_val("rst_tick", 32'(tick_out), 32'd0);
        check_val("rst_sync", 32'(sync_out), 32'd0);
        check_val("rst_err", 32'(frame_err_out), 32'd0);
        rst       = 1'b0;
        enable_in = 1'b1;
        sck_in    = 1'b1;
        ws_in     = 1'b1;
        sdi_in    = 1'b0;
        #200;
        check_val("quiet_sync", 32'(sync_out), 32'd0);
        check_val("quiet_ticks", 32'(tick_cnt), 32'd0);

        clear_slots();
        add_slot(1'b1, 4, '0);
        add_frame(24'hA5C3F1, 24'h123456);
        add_slot(1'b0, 1, '0);
        run_scenario("single", 1'b1);

        clear_slots();
        add_slot(1'b1, 4, '0);
        add_frame(24'h800000, 24'h7FFFFF);
        add_frame(24'h000000, 24'hFFFFFF);
        add_frame(24'($urandom), 24'($urandom));
        add_frame(24'($urandom), 24'($urandom));
        add_slot(1'b0, 1, '0);
        run_scenario("stream", 1'b1);

        clear_slots();
        add_slot(1'b1, 4, '0);
        add_slot(1'b0, SB - 1, 24'($urandom));
        add_slot(1'b1, SB, 24'($urandom));
        add_frame(24'($urandom), 24'($urandom));
        add_slot(1'b0, 1, '0);
        run_scenario("short", 1'b1);

        clear_slots();
        add_slot(1'b1, 4, '0);
        add_slot(1'b0, SB + 1, 24'($urandom));
        add_slot(1'b1, SB, 24'($urandom));
        add_frame(24'($urandom), 24'($urandom));
        add_slot(1'b0, 1, '0);
        run_scenario("long", 1'b1);

        clear_slots();
        add_slot(1'b1, 4, '0);
        add_frame(24'($urandom), 24'($urandom));
        add_slot(1'b0, SB, 24'($urandom));
        add_slot(1'b1, 10, 24'($urandom));
        run_scenario("pre_drop", 1'b0);
        t0 = tick_cnt;
        enable_in = 1'b0;
        #10;
        check_val("drop_sync", 32'(sync_out), 32'd0);
        check_val("drop_a0", 32'(audio0_out), 32'(hold_l));
        check_val("drop_a1", 32'(audio1_out), 32'(hold_r));
        #50;
        check_val("drop_ticks", 32'(tick_cnt - t0), 32'd0);
        enable_in = 1'b1;
        #20;
        clear_slots();
        add_slot(1'b1, SB - 10, '0);
        add_frame(24'($urandom), 24'($urandom));
        add_slot(1'b0, 1, '0);
        run_scenario("reenable", 1'b1);

        clear_slots();
        add_slot(1'b1, 4, '0);
        add_slot(1'b0, 10, 24'($urandom));
        run_scenario("pre_rst", 1'b0);
        rst = 1'b1;
        #1;
        check_val("arst_a0", 32'(audio0_out), 32'd0);
        check_val("arst_a1", 32'(audio1_out), 32'd0);
        check_val("arst_sync", 32'(sync_out), 32'd0);
        check_val("arst_tick", 32'(tick_out), 32'd0);
        #29;
        rst    = 1'b0;
        hold_l = '0;
        hold_r = '0;
        #20;
        clear_slots();
        add_slot(1'b1, 4, '0);
        add_frame(24'h000001, 24'h000002);
        add_slot(1'b0, 1, '0);
        run_scenario("post_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
